mc_ctrl: RTL

- Multi-cycle MIPS control unit: the opcode/funct producer on the far side of the ALU control interface.
- Latches each fetched instruction and sequences a shared datapath through FETCH/DECODE/execute states.
- Drives aluOp/shamt/operand selects; consumes the ALU zero flag for beq.
- Replaces single-cycle combinational decode when the datapath moves to one memory and one ALU reused across cycles.

---
 rtl/mc_ctrl.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl
// Description : Multi-cycle MIPS control unit. It latches the fetched
//               instruction into IR and sequences a shared datapath (one
//               memory, one ALU) through FETCH / DECODE / execute states.
//               All datapath controls are decoded from the current state and
//               IR. The only exception is the write enables, which are also
//               held low while reset is asserted.
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-high; forces FETCH and clears IR
//   instr    in   [31:0] memory read data, captured when irWrite=1
//   zero     in   ALU zero flag, used for beq
//   aluOp    out  [3:0] SLL=0 OR=1 ADD=2 LUI=3 SUB=4 XOR=6
//   shamt    out  [4:0] IR[10:6]
//   aluSrcA  out  0=PC, 1=rs
//   aluSrcB  out  [2:0] 0=rt 1=4 2=sext 3=zext 4=sext<<2
//   irWrite  out  load IR from instr
//   pcEn     out  PC enable (branch condition folded in)
//   pcSrc    out  [1:0] 0=aluRes 1=aluOut 2=jump target 3=rs
//   regWrite out  register file write enable
//   regDst   out  [1:0] 0=rt 1=rd 2=$31
//   memToReg out  [1:0] 0=aluOut 1=MDR 2=PC
//   memWrite out  data memory write enable
//   illegal  out  one-cycle pulse in DECODE for an unsupported encoding
//   state    out  [3:0] current state
//
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic [3:0]  aluOp,
    output logic [4:0]  shamt,
    output logic        aluSrcA,
    output logic [2:0]  aluSrcB,
    output logic        irWrite,
    output logic        pcEn,
    output logic [1:0]  pcSrc,
    output logic        regWrite,
    output logic [1:0]  regDst,
    output logic [1:0]  memToReg,
    output logic        memWrite,
    output logic        illegal,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_JR     = 4'd10
    } state_t;

    localparam logic [3:0] c_ALU_SLL = 4'd0;
    localparam logic [3:0] c_ALU_OR  = 4'd1;
    localparam logic [3:0] c_ALU_ADD = 4'd2;
    localparam logic [3:0] c_ALU_LUI = 4'd3;
    localparam logic [3:0] c_ALU_SUB = 4'd4;
    localparam logic [3:0] c_ALU_XOR = 4'd6;

    state_t      r_state;
    logic [31:0] r_ir;

    // Instruction fields
    logic [5:0] w_op;
    logic [5:0] w_funct;
    assign w_op    = r_ir[31:26];
    assign w_funct = r_ir[5:0];

    // Register/target fields are consumed by the datapath's own decode,
    // not by this controller.
    logic w_unused_ir;
    assign w_unused_ir = ^r_ir[25:11];

    // Instruction class decode
    logic w_rtype, w_r_alu, w_jr, w_lw, w_sw, w_ori, w_lui, w_addiu;
    logic w_beq, w_j, w_jal;
    logic [3:0] w_r_op;

    assign w_rtype = (w_op == 6'b000000);
    assign w_jr    = w_rtype && (w_funct == 6'b001000);
    assign w_lw    = (w_op == 6'b100011);
    assign w_sw    = (w_op == 6'b101011);
    assign w_ori   = (w_op == 6'b001101);
    assign w_lui   = (w_op == 6'b001111);
    assign w_addiu = (w_op == 6'b001001);
    assign w_beq   = (w_op == 6'b000100);
    assign w_j     = (w_op == 6'b000010);
    assign w_jal   = (w_op == 6'b000011);

    always_comb begin
        w_r_alu = 1'b1;
        w_r_op  = c_ALU_ADD;
        case (w_funct)
            6'b100000, 6'b100001: w_r_op = c_ALU_ADD;
            6'b100010, 6'b100011: w_r_op = c_ALU_SUB;
            6'b100101:            w_r_op = c_ALU_OR;
            6'b100110:            w_r_op = c_ALU_XOR;
            6'b000000:            w_r_op = c_ALU_SLL;
            default:              w_r_alu = 1'b0;
        endcase
        w_r_alu = w_r_alu && w_rtype;
    end

    // Selects and ALU op shared by EXEC and ALUWB so the result stays stable
    // across the write-back cycle.
    logic [3:0] w_exec_op;
    logic       w_exec_a;
    logic [2:0] w_exec_b;

    always_comb begin
        w_exec_op = c_ALU_ADD;
        w_exec_a  = 1'b1;
        w_exec_b  = 3'd0;
        if (w_r_alu) begin
            w_exec_op = w_r_op;
        end else if (w_ori) begin
            w_exec_op = c_ALU_OR;
            w_exec_b  = 3'd3;
        end else if (w_lui) begin
            w_exec_op = c_ALU_LUI;
            w_exec_b  = 3'd3;
        end else if (w_addiu) begin
            w_exec_op = c_ALU_ADD;
            w_exec_b  = 3'd2;
        end
    end

    // State-decoded controls, before reset gating of the enables
    logic   w_ir_write, w_pc_en, w_reg_write, w_mem_write, w_illegal;
    state_t w_next;

    always_comb begin
        aluOp       = c_ALU_ADD;
        aluSrcA     = 1'b0;
        aluSrcB     = 3'd0;
        pcSrc       = 2'd0;
        regDst      = 2'd0;
        memToReg    = 2'd0;
        w_ir_write  = 1'b0;
        w_pc_en     = 1'b0;
        w_reg_write = 1'b0;
        w_mem_write = 1'b0;
        w_illegal   = 1'b0;
        w_next      = S_FETCH;
        case (r_state)
            S_FETCH: begin
                aluSrcB    = 3'd1;
                w_ir_write = 1'b1;
                w_pc_en    = 1'b1;
                w_next     = S_DECODE;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into aluOut.
                aluSrcB = 3'd4;
                if (w_lw || w_sw)
                    w_next = S_MEMADR;
                else if (w_r_alu || w_ori || w_lui || w_addiu)
                    w_next = S_EXEC;
                else if (w_beq)
                    w_next = S_BRANCH;
                else if (w_j || w_jal)
                    w_next = S_JUMP;
                else if (w_jr)
                    w_next = S_JR;
                else
                    w_illegal = 1'b1;
            end
            S_MEMADR: begin
                aluSrcA = 1'b1;
                aluSrcB = 3'd2;
                w_next  = w_lw ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_reg_write = 1'b1;
                memToReg    = 2'd1;
            end
            S_MEMWR: begin
                w_mem_write = 1'b1;
            end
            S_EXEC: begin
                aluOp   = w_exec_op;
                aluSrcA = w_exec_a;
                aluSrcB = w_exec_b;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                aluOp       = w_exec_op;
                aluSrcA     = w_exec_a;
                aluSrcB     = w_exec_b;
                w_reg_write = 1'b1;
                regDst      = w_rtype ? 2'd1 : 2'd0;
            end
            S_BRANCH: begin
                aluSrcA = 1'b1;
                aluOp   = c_ALU_SUB;
                pcSrc   = 2'd1;
                w_pc_en = zero;
            end
            S_JUMP: begin
                pcSrc   = 2'd2;
                w_pc_en = 1'b1;
                // PC already holds jal+4 here, which becomes the link value.
                if (w_jal) begin
                    w_reg_write = 1'b1;
                    regDst      = 2'd2;
                    memToReg    = 2'd2;
                end
            end
            S_JR: begin
                pcSrc   = 2'd3;
                w_pc_en = 1'b1;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Enables are suppressed while reset is held so nothing is written.
    assign irWrite  = w_ir_write  & ~reset;
    assign pcEn     = w_pc_en     & ~reset;
    assign regWrite = w_reg_write & ~reset;
    assign memWrite = w_mem_write & ~reset;
    assign illegal  = w_illegal   & ~reset;
    assign shamt    = r_ir[10:6];
    assign state    = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= state_t'(RESET_STATE);
            r_ir    <= 32'd0;
        end else begin
            if (w_ir_write)
                r_ir <= instr;
            r_state <= w_next;
        end
    end

endmodule
`default_nettype wire
